// File: rtl/usb_tok_pkg.sv
// Shared definitions for the USB token transmitter: FSM states, field
// widths and the latched request layout.
package usb_tok_pkg;

    localparam int PID_BITS   = 8;
    localparam int FIELD_BITS = 11;
    localparam int CRC_BITS   = 5;
    localparam int CNT_W      = 5;

    // Counter values marking the last cycle/bit of each phase.
    localparam logic [CNT_W-1:0] PID_LAST   = CNT_W'(PID_BITS - 1);
    localparam logic [CNT_W-1:0] FIELD_LAST = CNT_W'(FIELD_BITS - 1);
    localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(CRC_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PID      = 3'd1,
        ST_FEED     = 3'd2,
        ST_WAIT_CRC = 3'd3,
        ST_CRC      = 3'd4,
        ST_REL      = 3'd5
    } tok_state_e;

    typedef struct packed {
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
    } tok_fields_t;

    // PID byte as it goes on the wire: pid[0] first, ~pid[3] last.
    function automatic logic [PID_BITS-1:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/token_tx_fsm.sv
// Token transmit sequencer: state register plus next-state and output
// decode. The phase counter lives in the parent; this block tells it when
// to advance, and exposes current/next state so the parent can clear the
// counter on every state entry.
module token_tx_fsm
    import usb_tok_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid_i,
    input  tok_fields_t      fields_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             crc5_out_i,
    input  logic             crc5_ready_i,
    input  logic             crc5_done_i,
    output tok_state_e       state_o,
    output tok_state_e       state_next_o,
    output logic             cnt_inc_o,
    output logic             tok_ready_o,
    output logic             tok_done_o,
    output logic             tok_err_o,
    output logic             tx_bit_o,
    output logic             tx_valid_o,
    output logic             tx_sop_o,
    output logic             tx_eop_o,
    output logic             crc5_start_o,
    output logic             crc_s_in_o,
    output logic             crc5_rec_o
);

    // TIMEOUT must fit the 5-bit phase counter (1..31).
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    tok_state_e state_q, state_d;
    logic [PID_BITS-1:0]   pid_vec;
    logic [FIELD_BITS-1:0] fld_vec;

    assign pid_vec      = pid_byte(fields_i.pid);
    assign fld_vec      = {fields_i.endp, fields_i.addr};
    assign state_o      = state_q;
    assign state_next_o = state_d;

    // State register; reset lands in IDLE from any state, mid-token included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; every output defaults low each cycle.
    always_comb begin
        state_d      = state_q;
        cnt_inc_o    = 1'b0;
        tok_ready_o  = 1'b0;
        tok_done_o   = 1'b0;
        tok_err_o    = 1'b0;
        tx_bit_o     = 1'b0;
        tx_valid_o   = 1'b0;
        tx_sop_o     = 1'b0;
        tx_eop_o     = 1'b0;
        crc5_start_o = 1'b0;
        crc_s_in_o   = 1'b0;
        crc5_rec_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tok_ready_o = 1'b1;
                if (tok_valid_i) begin
                    state_d = ST_PID;
                end
            end
            ST_PID: begin
                tx_valid_o = 1'b1;
                tx_bit_o   = pid_vec[cnt_i[2:0]];
                tx_sop_o   = (cnt_i == '0);
                cnt_inc_o  = 1'b1;
                if (cnt_i == PID_LAST) begin
                    // Start the CRC engine so it is primed for the first field bit.
                    crc5_start_o = 1'b1;
                    state_d      = ST_FEED;
                end
            end
            ST_FEED: begin
                tx_valid_o = 1'b1;
                tx_bit_o   = fld_vec[cnt_i[3:0]];
                crc_s_in_o = fld_vec[cnt_i[3:0]];
                cnt_inc_o  = 1'b1;
                if (cnt_i == FIELD_LAST) begin
                    state_d = ST_WAIT_CRC;
                end
            end
            ST_WAIT_CRC: begin
                cnt_inc_o = 1'b1;
                if (crc5_ready_i) begin
                    state_d = ST_CRC;
                end else if (cnt_i == TIMEOUT_CNT) begin
                    tok_err_o = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_CRC: begin
                // The engine paces the CRC bits; a low ready simply stalls.
                tx_bit_o   = crc5_out_i;
                tx_valid_o = crc5_ready_i;
                if (crc5_ready_i) begin
                    cnt_inc_o = 1'b1;
                    if (cnt_i == CRC_LAST) begin
                        tx_eop_o = 1'b1;
                        state_d  = ST_REL;
                    end
                end
            end
            ST_REL: begin
                if (crc5_done_i) begin
                    crc5_rec_o = 1'b1;
                    tok_done_o = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/token_tx_ctrl.sv
// USB token transmitter top: latches the request, owns the phase counter
// and wires the sequencer to the serial line and the external CRC5 engine.
//
// Request handshake: a token is accepted on a rising edge where tok_valid
// and tok_ready are both high. tok_ready is high only while idle, so
// tok_valid is ignored for the whole token; the latched fields then stay
// constant until the next acceptance.
module token_tx_ctrl
    import usb_tok_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tok_valid,
    input  logic [3:0] tok_pid,
    input  logic [6:0] tok_addr,
    input  logic [3:0] tok_endp,
    output logic       tok_ready,
    output logic       tok_done,
    output logic       tok_err,
    output logic       tx_bit,
    output logic       tx_valid,
    output logic       tx_sop,
    output logic       tx_eop,
    output logic       crc5_start,
    output logic       crc_s_in,
    output logic       crc5_rec,
    input  logic       crc5_out,
    input  logic       crc5_ready,
    input  logic       crc5_done
);

    tok_fields_t      fields_q, fields_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tok_state_e       state_q, state_d;
    logic             cnt_inc;
    logic             tok_ready_w;

    token_tx_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .tok_valid_i (tok_valid),
        .fields_i    (fields_q),
        .cnt_i       (cnt_q),
        .crc5_out_i  (crc5_out),
        .crc5_ready_i(crc5_ready),
        .crc5_done_i (crc5_done),
        .state_o     (state_q),
        .state_next_o(state_d),
        .cnt_inc_o   (cnt_inc),
        .tok_ready_o (tok_ready_w),
        .tok_done_o  (tok_done),
        .tok_err_o   (tok_err),
        .tx_bit_o    (tx_bit),
        .tx_valid_o  (tx_valid),
        .tx_sop_o    (tx_sop),
        .tx_eop_o    (tx_eop),
        .crc5_start_o(crc5_start),
        .crc_s_in_o  (crc_s_in),
        .crc5_rec_o  (crc5_rec)
    );

    assign tok_ready = tok_ready_w;

    // Capture the request fields only on an accepted handshake.
    always_comb begin
        fields_d = fields_q;
        if (tok_valid && tok_ready_w) begin
            fields_d = {tok_pid, tok_addr, tok_endp};
        end
    end

    // Phase counter: zero on every state entry, otherwise advance on request.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Field and counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields_q <= '0;
            cnt_q    <= '0;
        end else begin
            fields_q <= fields_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_token_tx_ctrl.sv
// Bench for token_tx_ctrl: drives token requests and a scripted CRC5
// engine, predicts every output cycle from the token timeline rules, and
// checks the serial stream against an expected-beat queue.
module tb_token_tx_ctrl;

    localparam int TIMEOUT = 16;
    localparam int NC      = 64;

    logic       clk, rst_n;
    logic       tok_valid;
    logic [3:0] tok_pid;
    logic [6:0] tok_addr;
    logic [3:0] tok_endp;
    logic       tok_ready, tok_done, tok_err;
    logic       tx_bit, tx_valid, tx_sop, tx_eop;
    logic       crc5_start, crc_s_in, crc5_rec;
    logic       crc5_out, crc5_ready, crc5_done;

    token_tx_ctrl #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tok_valid (tok_valid),
        .tok_pid   (tok_pid),
        .tok_addr  (tok_addr),
        .tok_endp  (tok_endp),
        .tok_ready (tok_ready),
        .tok_done  (tok_done),
        .tok_err   (tok_err),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .crc5_start(crc5_start),
        .crc_s_in  (crc_s_in),
        .crc5_rec  (crc5_rec),
        .crc5_out  (crc5_out),
        .crc5_ready(crc5_ready),
        .crc5_done (crc5_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Engine script, indexed by cycle relative to acceptance (cycle 0).
    bit sch_rdy [NC];
    bit sch_out [NC];
    bit sch_done[NC];

    // Expected per-cycle control outputs and the expected tx beat stream.
    bit exp_ready[NC];
    bit exp_valid[NC];
    bit exp_start[NC];
    bit exp_sin  [NC];
    bit exp_rec  [NC];
    bit exp_done [NC];
    bit exp_err  [NC];
    logic [2:0] exp_q[$];   // {sop, eop, bit}
    int last_c;

    int obs_done_c, obs_err_c, obs_eop_c, obs_rec_cnt;

    // Script the CRC engine: announce ready at rdy_on, then one CRC bit per
    // ready cycle with an optional stall before bit gap_after, then done.
    task automatic build_schedule(input logic [4:0] crc, input int rdy_on,
                                  input int gap_after, input int gap_len,
                                  input int done_lat);
        int c;
        for (int i = 0; i < NC; i++) begin
            sch_rdy[i] = 1'b0; sch_out[i] = 1'b0; sch_done[i] = 1'b0;
        end
        if (rdy_on >= 0) begin
            c = rdy_on;
            sch_rdy[c] = 1'b1;
            for (int k = 0; k < 5; k++) begin
                c++;
                if (k == gap_after) c += gap_len;
                sch_rdy[c] = 1'b1;
                sch_out[c] = crc[k];
            end
            sch_done[c + done_lat] = 1'b1;
        end
    endtask

    // Reference timeline: PID bits at 1-8, field bits at 9-19, wait from 20
    // until the engine is ready or TIMEOUT cycles pass, CRC bits on each
    // following ready cycle, release on the first done cycle afterwards.
    task automatic build_expect(input logic [3:0] pid, input logic [6:0] addr,
                                input logic [3:0] endp);
        logic [7:0]  pb;
        logic [10:0] fb;
        int w, n, c;
        for (int i = 0; i < NC; i++) begin
            exp_ready[i] = 1'b0; exp_valid[i] = 1'b0; exp_start[i] = 1'b0;
            exp_sin[i] = 1'b0; exp_rec[i] = 1'b0; exp_done[i] = 1'b0; exp_err[i] = 1'b0;
        end
        exp_q.delete();
        pb = {~pid, pid};
        fb = {endp, addr};
        exp_ready[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_valid[1 + k] = 1'b1;
            exp_q.push_back({(k == 0), 1'b0, pb[k]});
        end
        exp_start[8] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            exp_valid[9 + k] = 1'b1;
            exp_sin[9 + k]   = fb[k];
            exp_q.push_back({1'b0, 1'b0, fb[k]});
        end
        w = -1;
        for (int i = 20; i <= 20 + TIMEOUT; i++) begin
            if (w < 0 && sch_rdy[i]) w = i;
        end
        if (w < 0) begin
            exp_err[20 + TIMEOUT] = 1'b1;
            last_c = 20 + TIMEOUT;
        end else begin
            n = 0;
            c = w + 1;
            while (n < 5 && c < NC) begin
                if (sch_rdy[c]) begin
                    exp_valid[c] = 1'b1;
                    exp_q.push_back({1'b0, (n == 4), sch_out[c]});
                    n++;
                end
                c++;
            end
            while (c < NC - 1 && !sch_done[c]) c++;
            exp_rec[c]  = 1'b1;
            exp_done[c] = 1'b1;
            last_c = c;
        end
    endtask

    // Drive one token from its acceptance cycle, checking every cycle.
    // Entered and left in the drive slot just after a rising edge.
    task automatic run_token(input logic [3:0] pid, input logic [6:0] addr,
                             input logic [3:0] endp, input logic [4:0] crc,
                             input int rdy_on, input int gap_after, input int gap_len,
                             input int done_lat, input bit hold, input int stop_at);
        logic [2:0] beat;
        build_schedule(crc, rdy_on, gap_after, gap_len, done_lat);
        build_expect(pid, addr, endp);
        obs_done_c = -1; obs_err_c = -1; obs_eop_c = -1; obs_rec_cnt = 0;
        for (int c = 0; c <= last_c && c != stop_at; c++) begin
            tok_valid = (c == 0 || hold) ? 1'b1 : 1'($urandom_range(0, 1));
            if (c == 0) begin
                tok_pid = pid; tok_addr = addr; tok_endp = endp;
            end else begin
                tok_pid = 4'($urandom); tok_addr = 7'($urandom); tok_endp = 4'($urandom);
            end
            crc5_ready = sch_rdy[c];
            crc5_out   = sch_rdy[c] ? sch_out[c] : 1'($urandom);
            crc5_done  = sch_done[c];
            @(negedge clk);
            checks++;
            if (tok_ready !== exp_ready[c]) begin
                failures++; $display("FAIL tok_ready c=%0d got=%b exp=%b", c, tok_ready, exp_ready[c]);
            end
            checks++;
            if (tx_valid !== exp_valid[c]) begin
                failures++; $display("FAIL tx_valid c=%0d got=%b exp=%b", c, tx_valid, exp_valid[c]);
            end
            checks++;
            if (crc5_start !== exp_start[c]) begin
                failures++; $display("FAIL crc5_start c=%0d got=%b exp=%b", c, crc5_start, exp_start[c]);
            end
            checks++;
            if (crc_s_in !== exp_sin[c]) begin
                failures++; $display("FAIL crc_s_in c=%0d got=%b exp=%b", c, crc_s_in, exp_sin[c]);
            end
            checks++;
            if (crc5_rec !== exp_rec[c]) begin
                failures++; $display("FAIL crc5_rec c=%0d got=%b exp=%b", c, crc5_rec, exp_rec[c]);
            end
            checks++;
            if (tok_done !== exp_done[c]) begin
                failures++; $display("FAIL tok_done c=%0d got=%b exp=%b", c, tok_done, exp_done[c]);
            end
            checks++;
            if (tok_err !== exp_err[c]) begin
                failures++; $display("FAIL tok_err c=%0d got=%b exp=%b", c, tok_err, exp_err[c]);
            end
            checks++;
            if (tx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL tx_beat c=%0d got=%b exp=none", c, {tx_sop, tx_eop, tx_bit});
                end else begin
                    beat = exp_q.pop_front();
                    if ({tx_sop, tx_eop, tx_bit} !== beat) begin
                        failures++; $display("FAIL tx_beat c=%0d got=%b exp=%b", c, {tx_sop, tx_eop, tx_bit}, beat);
                    end
                end
            end else if ({tx_sop, tx_eop} !== 2'b00) begin
                failures++; $display("FAIL sop_eop_idle c=%0d got=%b exp=00", c, {tx_sop, tx_eop});
            end
            if (tok_done === 1'b1) obs_done_c = c;
            if (tok_err === 1'b1) obs_err_c = c;
            if (tx_eop === 1'b1) obs_eop_c = c;
            if (crc5_rec === 1'b1) obs_rec_cnt++;
            @(posedge clk);
            #1;
        end
        if (stop_at < 0) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++; $display("FAIL tx_beats_left got=%0d exp=0", exp_q.size());
            end
        end
        if (!hold) tok_valid = 1'b0;
        crc5_ready = 1'b0; crc5_out = 1'b0; crc5_done = 1'b0;
    endtask

    // Idle-output check used right after reset and between scenarios.
    task automatic test_reset();
        rst_n = 1'b0;
        tok_valid = 1'b0; tok_pid = '0; tok_addr = '0; tok_endp = '0;
        crc5_out = 1'b0; crc5_ready = 1'b0; crc5_done = 1'b0;
        #3;
        checks++;
        if (tok_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", tok_ready);
        end
        checks++;
        if ({tok_done, tok_err, tx_bit, tx_valid, tx_sop, tx_eop, crc5_start, crc_s_in, crc5_rec} !== 9'b0) begin
            failures++; $display("FAIL reset_outs got=%b exp=0", {tok_done, tok_err, tx_bit, tx_valid, tx_sop, tx_eop, crc5_start, crc_s_in, crc5_rec});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tok_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_ready got=%b exp=1", tok_ready);
        end
        checks++;
        if ({tok_done, tok_err, tx_bit, tx_valid, tx_sop, tx_eop, crc5_start, crc_s_in, crc5_rec} !== 9'b0) begin
            failures++; $display("FAIL post_reset_outs got=%b exp=0", {tok_done, tok_err, tx_bit, tx_valid, tx_sop, tx_eop, crc5_start, crc_s_in, crc5_rec});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [4:0] ref_crc;
        ref_crc = 5'b10111;
        run_token(4'h9, 7'h15, 4'hE, ref_crc, 26, 5, 0, 2, 1'b0, -1);
        checks++;
        if (obs_eop_c !== 31) begin
            failures++; $display("FAIL basic_eop_cycle got=%0d exp=31", obs_eop_c);
        end
        checks++;
        if (obs_done_c !== 33) begin
            failures++; $display("FAIL basic_done_cycle got=%0d exp=33", obs_done_c);
        end
        @(negedge clk);
        checks++;
        if (tok_ready !== 1'b1) begin
            failures++; $display("FAIL basic_ready_34 got=%b exp=1", tok_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        run_token(4'h1, 7'h7F, 4'h0, 5'b0, -1, 5, 0, 1, 1'b0, -1);
        checks++;
        if (obs_err_c !== 20 + TIMEOUT) begin
            failures++; $display("FAIL timeout_err_cycle got=%0d exp=%0d", obs_err_c, 20 + TIMEOUT);
        end
        checks++;
        if (obs_rec_cnt !== 0) begin
            failures++; $display("FAIL timeout_rec got=%0d exp=0", obs_rec_cnt);
        end
        @(negedge clk);
        checks++;
        if (tok_ready !== 1'b1) begin
            failures++; $display("FAIL timeout_idle got=%b exp=1", tok_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        run_token(4'hD, 7'h2A, 4'h5, 5'b01101, 26, 5, 0, 2, 1'b1, -1);
        checks++;
        if (obs_done_c !== 33) begin
            failures++; $display("FAIL b2b_first_done got=%0d exp=33", obs_done_c);
        end
        run_token(4'h3, 7'h41, 4'hA, 5'b11000, 24, 5, 0, 3, 1'b0, -1);
        checks++;
        if (obs_done_c !== 32) begin
            failures++; $display("FAIL b2b_second_done got=%0d exp=32", obs_done_c);
        end
    endtask

    task automatic test_crc_stall();
        run_token(4'h5, 7'h33, 4'h9, 5'b10010, 26, 2, 3, 2, 1'b0, -1);
        checks++;
        if (obs_eop_c !== 34) begin
            failures++; $display("FAIL stall_eop_cycle got=%0d exp=34", obs_eop_c);
        end
        checks++;
        if (obs_done_c !== 36) begin
            failures++; $display("FAIL stall_done_cycle got=%0d exp=36", obs_done_c);
        end
    endtask

    task automatic test_late_done();
        run_token(4'hB, 7'h0C, 4'h3, 5'b00111, 26, 5, 0, 10, 1'b0, -1);
        checks++;
        if (obs_done_c !== 41) begin
            failures++; $display("FAIL late_done_cycle got=%0d exp=41", obs_done_c);
        end
        checks++;
        if (obs_rec_cnt !== 1) begin
            failures++; $display("FAIL late_rec_count got=%0d exp=1", obs_rec_cnt);
        end
    endtask

    task automatic test_reset_mid();
        // Stop in the drive slot of cycle 14, i.e. while FEED bit 5 is out.
        run_token(4'h6, 7'h55, 4'hC, 5'b01010, 26, 5, 0, 2, 1'b0, 14);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tok_ready, tok_done, tok_err, tx_bit, tx_valid, tx_sop, tx_eop, crc5_start, crc_s_in, crc5_rec} !== 10'b1000000000) begin
            failures++; $display("FAIL midreset_outs got=%b exp=1000000000", {tok_ready, tok_done, tok_err, tx_bit, tx_valid, tx_sop, tx_eop, crc5_start, crc_s_in, crc5_rec});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({tok_ready, tok_done, tok_err, tx_bit, tx_valid, tx_sop, tx_eop, crc5_start, crc_s_in, crc5_rec} !== 10'b1000000000) begin
                failures++; $display("FAIL midreset_idle i=%0d got=%b exp=1000000000", i, {tok_ready, tok_done, tok_err, tx_bit, tx_valid, tx_sop, tx_eop, crc5_start, crc_s_in, crc5_rec});
            end
            @(posedge clk);
            #1;
        end
        run_token(4'hE, 7'h12, 4'h7, 5'b11101, 26, 5, 0, 2, 1'b0, -1);
        checks++;
        if (obs_done_c !== 33) begin
            failures++; $display("FAIL midreset_next_done got=%0d exp=33", obs_done_c);
        end
    endtask

    task automatic test_random();
        int rdy, gap_after, gap_len, done_lat;
        bit hold;
        for (int i = 0; i < 8; i++) begin
            rdy       = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(20, 28));
            gap_after = int'($urandom_range(0, 5));
            gap_len   = int'($urandom_range(0, 4));
            done_lat  = int'($urandom_range(1, 4));
            hold      = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_token(4'($urandom), 7'($urandom), 4'($urandom), 5'($urandom),
                      rdy, gap_after, gap_len, done_lat, hold, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_back_to_back();
        test_crc_stall();
        test_late_done();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
